axi_req_arbiter: RTL and testbench
==================================

Name: axi_req_arbiter

Overview:
Shares the single AXI read/write master between the instruction cache (line fills) and the data cache (line fills and dirty write-backs). It grants one request at a time and latches that request's address and write block. It holds the master's start signal until the master reports completion, then returns the 512-bit read block to the owner with a one-cycle done pulse. It sits between both caches and the AXI master block.

Parameters:
ADDR_WIDTH, 64, address width; matches the master's AXI address width.
BLOCK_WIDTH, 512, cache line width in bits; matches the master's data width.

Ports:
clk  input  1  clock
arstn  input  1  asynchronous active-low reset
i_ic_req_read  input  1  icache line-fill request; level
i_ic_addr  input  ADDR_WIDTH  icache fill address
o_ic_data  output  BLOCK_WIDTH  icache fill block; valid while o_ic_done=1
o_ic_done  output  1  one-cycle icache completion pulse
i_dc_req_read  input  1  dcache line-fill request; level
i_dc_req_write  input  1  dcache write-back request; level
i_dc_addr  input  ADDR_WIDTH  dcache address
i_dc_wdata  input  BLOCK_WIDTH  dcache write-back block
o_dc_data  output  BLOCK_WIDTH  dcache fill block; valid while o_dc_done=1
o_dc_done  output  1  one-cycle dcache completion pulse
o_mst_addr  output  ADDR_WIDTH  latched address to the master
o_mst_wdata  output  BLOCK_WIDTH  latched write block to the master
o_mst_start_read  output  1  master read start; held for the whole transaction
o_mst_start_write  output  1  master write start; held for the whole transaction
i_mst_rdata  input  BLOCK_WIDTH  master assembled read block
i_mst_read_last  input  1  master's last read beat (R_LAST)
i_mst_b_resp  input  1  master write response OKAY pulse
o_busy  output  1  high when state is not IDLE

Behaviour:
- Reset (async, arstn=0):
  - State goes to IDLE.
  - All outputs go to 0, including both data registers and the latched address/wdata.
  - Round-robin pointer rr goes to 0 (icache favoured).
  - Reset mid-transaction drops both starts immediately; no done pulse is issued.
- States: IDLE, RD, WR, CPL, RSP. A 1-bit owner register (0=ic, 1=dc) is set at grant.
- IDLE, grant priority:
  1. i_dc_req_write → WR, owner=dc. Write-back always precedes any fill.
  2. Both reads pending → the rr side wins; rr toggles to the other side after every read grant.
  3. A single pending read → RD to that side.
- On grant, o_mst_addr and o_mst_wdata load from the winner at the IDLE→RD/WR edge. wdata loads only for WR, otherwise it holds.
- RD:
  - o_mst_start_read=1.
  - Go to CPL at the edge where i_mst_read_last=1.
- WR:
  - o_mst_start_write=1.
  - Go to CPL at the edge where i_mst_b_resp=1.
  - A non-OKAY response never pulses b_resp; WR waits indefinitely. There is no timeout.
- CPL (1 cycle):
  - Both starts are 0.
  - If the transaction was a read, i_mst_rdata loads into the owner's data register at the end of this cycle; the master's block is final here.
  - Go to RSP.
- RSP (1 cycle):
  - The owner's done=1 and its data register is valid. The other cache's done=0.
  - Writes pulse done but leave the data register unchanged.
  - Go to IDLE.
- Requester contract:
  - Hold req, address and wdata stable from assertion until done is sampled.
  - Deassert req at the edge ending RSP, so IDLE never re-grants a completed request.
- Data registers hold their value after done until the next completed read for that side.
- A request raised while busy waits in IDLE. There is no pre-emption; the starts are never both high.
- dcache read and write asserted together: write is served first. The read is served on a later IDLE arbitration, where round-robin with the icache applies.
- o_mst_* outputs are registered and glitch-free.
- Latency:
  - Read: grant edge → start=1 in the first RD cycle. read_last cycle + 2 → done.
  - Write: grant edge → start=1 in the first WR cycle. b_resp cycle + 2 → done.

Test Plan:
1. ic read only, addr 0x1000; master returns 16 beats, read_last on beat 16, rdata=pattern A → start_read held 16+ cycles; o_ic_done 2 cycles after read_last; o_ic_data=A; o_dc_done stays 0.
2. ic and dc read raised in the same cycle after reset → ic granted first (addr=ic_addr); dc granted in the IDLE cycle after ic RSP; rr alternates over 4 back-to-back pairs (ic,dc,ic,dc).
3. dc write (addr 0x2000, wdata=B) together with ic read → WR first; o_mst_wdata=B; start_write held until b_resp; o_dc_done 2 cycles later; o_dc_data unchanged; then ic read granted.
4. dc write and dc read asserted together → write completes and done pulses; read then served with rdata=C → o_dc_data=C.
5. arstn low during RD mid-burst → start_read=0 immediately; state IDLE; no done pulse; a new request after release is granted normally.
6. b_resp withheld for 100 cycles → arbiter stays in WR, o_busy=1, no done; a late b_resp completes normally.

Source files
------------

// File: rtl/axi_req_arbiter.sv
// Purpose: shares one AXI read/write master between icache fills and dcache fills/write-backs.
// Latency: start in the first cycle after grant; done two cycles after read_last / b_resp.
// Backpressure: one transaction in flight; other requests wait (level) in IDLE until it retires.
module axi_req_arbiter #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   i_ic_req_read,
   input  logic [ADDR_WIDTH-1:0]  i_ic_addr,
   output logic [BLOCK_WIDTH-1:0] o_ic_data,
   output logic                   o_ic_done,
   input  logic                   i_dc_req_read,
   input  logic                   i_dc_req_write,
   input  logic [ADDR_WIDTH-1:0]  i_dc_addr,
   input  logic [BLOCK_WIDTH-1:0] i_dc_wdata,
   output logic [BLOCK_WIDTH-1:0] o_dc_data,
   output logic                   o_dc_done,
   output logic [ADDR_WIDTH-1:0]  o_mst_addr,
   output logic [BLOCK_WIDTH-1:0] o_mst_wdata,
   output logic                   o_mst_start_read,
   output logic                   o_mst_start_write,
   input  logic [BLOCK_WIDTH-1:0] i_mst_rdata,
   input  logic                   i_mst_read_last,
   input  logic                   i_mst_b_resp,
   output logic                   o_busy
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CPL, S_RSP} state_e;

   state_e                 state_q, state_d;
   logic                   owner_q, owner_d;     // 0 = icache, 1 = dcache
   logic                   is_wr_q, is_wr_d;
   logic                   rr_q, rr_d;           // side that wins a read tie
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
   logic [BLOCK_WIDTH-1:0] ic_data_q, ic_data_d;
   logic [BLOCK_WIDTH-1:0] dc_data_q, dc_data_d;
   logic                   start_rd_q, start_rd_d;
   logic                   start_wr_q, start_wr_d;
   logic                   ic_done_q, ic_done_d;
   logic                   dc_done_q, dc_done_d;
   logic                   rd_pend;
   logic                   rd_to_dc;

   // Read arbitration: a tie goes to the round-robin side, otherwise to whoever asks.
   always_comb begin
      rd_pend  = i_ic_req_read | i_dc_req_read;
      rd_to_dc = (i_ic_req_read & i_dc_req_read) ? rr_q : i_dc_req_read;
   end

   // Next-state and next-output logic; starts and dones are derived from the next state so
   // every master-facing and cache-facing strobe leaves a flop.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      is_wr_d   = is_wr_q;
      rr_d      = rr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ic_data_d = ic_data_q;
      dc_data_d = dc_data_q;
      case (state_q)
         S_IDLE: begin
            if (i_dc_req_write) begin
               // Write-back goes first so a dirty victim is out before its refill.
               state_d = S_WR;
               owner_d = 1'b1;
               is_wr_d = 1'b1;
               addr_d  = i_dc_addr;
               wdata_d = i_dc_wdata;
            end else if (rd_pend) begin
               state_d = S_RD;
               owner_d = rd_to_dc;
               is_wr_d = 1'b0;
               addr_d  = rd_to_dc ? i_dc_addr : i_ic_addr;
               // Point the tie-breaker at the side that did not just win.
               rr_d    = ~rd_to_dc;
            end
         end
         S_RD:    if (i_mst_read_last) state_d = S_CPL;
         S_WR:    if (i_mst_b_resp)    state_d = S_CPL;
         S_CPL: begin
            // The master's assembled block is final in this cycle.
            if (!is_wr_q) begin
               if (owner_q) dc_data_d = i_mst_rdata;
               else         ic_data_d = i_mst_rdata;
            end
            state_d = S_RSP;
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      start_rd_d = (state_d == S_RD);
      start_wr_d = (state_d == S_WR);
      ic_done_d  = (state_d == S_RSP) & ~owner_d;
      dc_done_d  = (state_d == S_RSP) &  owner_d;
   end

   // State and datapath registers; reset clears everything, including the data blocks.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         is_wr_q    <= 1'b0;
         rr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ic_data_q  <= '0;
         dc_data_q  <= '0;
         start_rd_q <= 1'b0;
         start_wr_q <= 1'b0;
         ic_done_q  <= 1'b0;
         dc_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         is_wr_q    <= is_wr_d;
         rr_q       <= rr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ic_data_q  <= ic_data_d;
         dc_data_q  <= dc_data_d;
         start_rd_q <= start_rd_d;
         start_wr_q <= start_wr_d;
         ic_done_q  <= ic_done_d;
         dc_done_q  <= dc_done_d;
      end
   end

   assign o_mst_addr        = addr_q;
   assign o_mst_wdata       = wdata_q;
   assign o_mst_start_read  = start_rd_q;
   assign o_mst_start_write = start_wr_q;
   assign o_ic_data         = ic_data_q;
   assign o_dc_data         = dc_data_q;
   assign o_ic_done         = ic_done_q;
   assign o_dc_done         = dc_done_q;
   assign o_busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Purpose: self-checking bench for axi_req_arbiter with a transaction-level reference model.
// Latency: checks start on grant+1, done exactly two cycles after read_last / b_resp.
// Backpressure: master completion is delayed 1..100 cycles to exercise held starts.
module tb_axi_req_arbiter;

   localparam int AW = 64;
   localparam int BW = 512;

   logic          clk = 1'b0;
   logic          arstn;
   logic          i_ic_req_read, i_dc_req_read, i_dc_req_write;
   logic [AW-1:0] i_ic_addr, i_dc_addr;
   logic [BW-1:0] i_dc_wdata, i_mst_rdata;
   logic          i_mst_read_last, i_mst_b_resp;
   logic [BW-1:0] o_ic_data, o_dc_data, o_mst_wdata;
   logic          o_ic_done, o_dc_done, o_mst_start_read, o_mst_start_write, o_busy;
   logic [AW-1:0] o_mst_addr;

   int tests  = 0;
   int failed = 0;

   // Reference model state: last data handed to each cache, last write block, tie-break side.
   logic [BW-1:0] ic_data_m, dc_data_m, wdata_m;
   bit            rr_m;  // 0 = icache wins a read tie, 1 = dcache

   typedef struct {
      bit ic; bit dcr; bit dcw;   // requests newly raised before this transaction
      int lat;                    // cycles the start is held before completion
      bit exp_wr; bit exp_dc;     // expected grant
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   axi_req_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
      .clk(clk), .arstn(arstn),
      .i_ic_req_read(i_ic_req_read), .i_ic_addr(i_ic_addr),
      .o_ic_data(o_ic_data), .o_ic_done(o_ic_done),
      .i_dc_req_read(i_dc_req_read), .i_dc_req_write(i_dc_req_write),
      .i_dc_addr(i_dc_addr), .i_dc_wdata(i_dc_wdata),
      .o_dc_data(o_dc_data), .o_dc_done(o_dc_done),
      .o_mst_addr(o_mst_addr), .o_mst_wdata(o_mst_wdata),
      .o_mst_start_read(o_mst_start_read), .o_mst_start_write(o_mst_start_write),
      .i_mst_rdata(i_mst_rdata), .i_mst_read_last(i_mst_read_last),
      .i_mst_b_resp(i_mst_b_resp), .o_busy(o_busy)
   );

   function automatic logic [BW-1:0] rand512();
      logic [BW-1:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected grant {write, dcache} from the pending requests.
   function automatic logic [1:0] pick();
      if (i_dc_req_write)                  return 2'b11;
      if (i_ic_req_read && i_dc_req_read)  return {1'b0, rr_m};
      if (i_dc_req_read)                   return 2'b01;
      return 2'b00;
   endfunction

   // Raise level requests; an address/block only changes when that cache has nothing pending.
   task automatic raise(input bit ic, input bit dcr, input bit dcw);
      if (ic && !i_ic_req_read) begin
         i_ic_addr     = {$urandom, $urandom};
         i_ic_req_read = 1'b1;
      end
      if ((dcr || dcw) && !i_dc_req_read && !i_dc_req_write) begin
         i_dc_addr  = {$urandom, $urandom};
         i_dc_wdata = rand512();
      end
      if (dcr) i_dc_req_read  = 1'b1;
      if (dcw) i_dc_req_write = 1'b1;
   endtask

   // Act as master for one transaction and as requester retiring it. Called at a negedge.
   task automatic serve(input int lat, input bit exp_wr, input bit exp_dc);
      int            n;
      bit            held;
      logic [BW-1:0] d_fin;
      n = 0;
      @(negedge clk);
      chk("done_one_cycle", {o_ic_done, o_dc_done}, 2'b00);
      while (!(o_mst_start_read || o_mst_start_write) && n < 3) begin
         @(negedge clk);
         n++;
      end
      chk("grant_prompt", (n <= 1), 1'b1);
      chk("grant_type", {o_mst_start_read, o_mst_start_write}, exp_wr ? 2'b01 : 2'b10);
      chk("grant_addr", o_mst_addr, exp_dc ? i_dc_addr : i_ic_addr);
      if (exp_wr) wdata_m = i_dc_wdata;
      chk("grant_wdata", o_mst_wdata, wdata_m);
      held = 1'b1;
      for (int j = 1; j <= lat; j++) begin
         if (j > 1) @(negedge clk);
         held = held && (o_mst_start_read == !exp_wr) && (o_mst_start_write == exp_wr)
                     && o_busy && !o_ic_done && !o_dc_done;
         if (j == lat) begin
            if (exp_wr) i_mst_b_resp = 1'b1;
            else        i_mst_read_last = 1'b1;
            i_mst_rdata = rand512();   // not yet final
         end
      end
      chk("start_held", held, 1'b1);
      @(negedge clk);  // CPL
      i_mst_read_last = 1'b0;
      i_mst_b_resp    = 1'b0;
      chk("cpl_quiet", {o_mst_start_read, o_mst_start_write, o_ic_done, o_dc_done, o_busy}, 5'b00001);
      d_fin       = rand512();
      i_mst_rdata = d_fin;
      @(negedge clk);  // RSP
      if (!exp_wr) begin
         if (exp_dc) dc_data_m = d_fin;
         else        ic_data_m = d_fin;
         rr_m = !exp_dc;
      end
      chk("done_side", {o_ic_done, o_dc_done}, exp_dc ? 2'b01 : 2'b10);
      chk("ic_data", o_ic_data, ic_data_m);
      chk("dc_data", o_dc_data, dc_data_m);
      i_mst_rdata = rand512();
      if (exp_wr)      i_dc_req_write = 1'b0;
      else if (exp_dc) i_dc_req_read  = 1'b0;
      else             i_ic_req_read  = 1'b0;
   endtask

   initial begin
      logic [1:0] p;
      int         n;
      // {ic, dcr, dcw, lat, exp_wr, exp_dc}
      vecs[0] = '{1, 1, 0, 16,  0, 0};  // tie after reset: icache first
      vecs[1] = '{1, 0, 0, 16,  0, 1};  // tie again: dcache's turn
      vecs[2] = '{0, 1, 0, 5,   0, 0};
      vecs[3] = '{1, 0, 0, 5,   0, 1};
      vecs[4] = '{0, 0, 1, 7,   1, 1};  // write-back beats a pending icache fill
      vecs[5] = '{0, 0, 0, 3,   0, 0};
      vecs[6] = '{0, 1, 1, 4,   1, 1};  // dcache write and read together: write first
      vecs[7] = '{0, 0, 0, 4,   0, 1};
      vecs[8] = '{1, 0, 0, 1,   0, 0};  // shortest burst
      vecs[9] = '{0, 0, 1, 100, 1, 1};  // write response withheld for 100 cycles

      arstn = 1'b0;
      i_ic_req_read = 1'b0; i_dc_req_read = 1'b0; i_dc_req_write = 1'b0;
      i_ic_addr = '0; i_dc_addr = '0; i_dc_wdata = '0;
      i_mst_rdata = '0; i_mst_read_last = 1'b0; i_mst_b_resp = 1'b0;
      ic_data_m = '0; dc_data_m = '0; wdata_m = '0; rr_m = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ctrl", {o_busy, o_mst_start_read, o_mst_start_write, o_ic_done, o_dc_done}, 5'b0);
      chk("rst_addr", o_mst_addr, '0);
      chk("rst_wdata", o_mst_wdata, '0);
      chk("rst_ic_data", o_ic_data, '0);
      chk("rst_dc_data", o_dc_data, '0);
      #3 arstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         raise(vecs[i].ic, vecs[i].dcr, vecs[i].dcw);
         serve(vecs[i].lat, vecs[i].exp_wr, vecs[i].exp_dc);
      end

      for (int i = 0; i < 40; i++) begin
         raise($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         if (!i_ic_req_read && !i_dc_req_read && !i_dc_req_write) raise(1, 0, 0);
         p = pick();
         serve($urandom_range(1, 20), p[1], p[0]);
      end

      // Drain whatever the random phase left pending.
      for (int i = 0; i < 3 && (i_ic_req_read || i_dc_req_read || i_dc_req_write); i++) begin
         p = pick();
         serve($urandom_range(1, 6), p[1], p[0]);
      end

      // Reset in the middle of a read burst.
      raise(1, 0, 0);
      n = 0;
      while (!o_mst_start_read && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_grant", o_mst_start_read, 1'b1);
      repeat (3) @(negedge clk);
      #2 arstn = 1'b0;
      #1;
      chk("midrst_ctrl", {o_busy, o_mst_start_read, o_mst_start_write, o_ic_done, o_dc_done}, 5'b0);
      chk("midrst_addr", o_mst_addr, '0);
      chk("midrst_data", {o_ic_data[63:0], o_dc_data[63:0]}, '0);
      i_ic_req_read = 1'b0;
      ic_data_m = '0; dc_data_m = '0; wdata_m = '0; rr_m = 1'b0;
      @(negedge clk);
      chk("midrst_hold", {o_busy, o_mst_start_read, o_ic_done, o_dc_done}, 4'b0);
      #3 arstn = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {o_busy, o_ic_done, o_dc_done}, 3'b0);
      raise(1, 1, 0);
      p = pick();
      serve(6, p[1], p[0]);
      p = pick();
      serve(6, p[1], p[0]);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
